// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave: byte width, SPI mode and FSM encoding.
package spi_slave_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned SPI_MODE  = 3;
    localparam int unsigned BIT_CNT_W = $clog2(BYTE_W);

    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
    typedef logic [BYTE_W-1:0]    byte_t;

    localparam bit_cnt_t LAST_BIT = bit_cnt_t'(BYTE_W - 1);

    // Idle level of sclk follows CPOL, the upper bit of the mode number.
    localparam logic SCLK_IDLE = 1'((SPI_MODE >> 1) & 1);

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Pin and byte-stream bundle between an SPI slave and its surroundings.
interface spi_slave_if;
    import spi_slave_pkg::*;

    logic  cs_n;
    logic  sclk;
    logic  mosi;
    logic  miso;
    logic  miso_oe;
    byte_t tx_din;
    logic  tx_load;
    logic  tx_ready;
    byte_t rx_dout;
    logic  rx_valid;
    logic  tx_underrun;
    logic  busy;

    modport slave (
        input  cs_n, sclk, mosi, tx_din, tx_load,
        output miso, miso_oe, tx_ready, rx_dout, rx_valid, tx_underrun, busy
    );

    modport master (
        output cs_n, sclk, mosi, tx_din, tx_load,
        input  miso, miso_oe, tx_ready, rx_dout, rx_valid, tx_underrun, busy
    );

endinterface

// File: rtl/spi_sync.sv
// N-stage synchronizer with registered rise/fall detection against a delayed copy.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Shift the async input through the chain and register edge events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 slave: oversampled pins, byte-wide rx/tx with a one-byte tx holding register.
module spi_slave import spi_slave_pkg::*; #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter byte_t       DUMMY_BYTE  = 8'hFF
) (
    input logic        clk,
    input logic        rst_n,
    spi_slave_if.slave bus
);

    // Chain plus the prev/edge registers must hold pin-derived values before edges are trusted.
    localparam logic [2:0] FLUSH_CYCLES = 3'(SYNC_STAGES + 2);

    logic cs_q, cs_rise, cs_fall;
    logic sclk_q, sclk_rise, sclk_fall;
    logic mosi_q;

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [2:0]             flush_cnt_q;
    logic                   flushed;
    logic                   armed_q;

    state_e   state_q, state_d;
    bit_cnt_t bit_cnt_q, bit_cnt_d;
    byte_t    rx_shift_q, rx_shift_d;
    byte_t    rx_dout_q, rx_dout_d;
    logic     rx_valid_q, rx_valid_d;
    byte_t    tx_shift_q, tx_shift_d;
    byte_t    hold_q, hold_d;
    logic     hold_full_q, hold_full_d;
    logic     underrun_q, underrun_d;
    logic     take_hold;

    spi_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.cs_n),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (SCLK_IDLE)
    ) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.sclk),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // mosi only needs its level; it is stable for many clk around each sclk rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    assign mosi_q  = mosi_sync_q[SYNC_STAGES-1];
    assign flushed = (flush_cnt_q == FLUSH_CYCLES);

    // Arm only after the bus has been seen idle, so a cs_n held low through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            if (!flushed) begin
                flush_cnt_q <= flush_cnt_q + 3'd1;
            end
            if (flushed && cs_q && (sclk_q == SCLK_IDLE)) begin
                armed_q <= 1'b1;
            end
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_dout_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_dout_q   <= rx_dout_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
        end
    end

    // Next-state: frame control, rx assembly on sclk rise, tx shifting on sclk fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_dout_d   = rx_dout_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        take_hold   = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall && armed_q) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    // Abandon any partial byte; holding register is left alone.
                    state_d    = StIdle;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_q};
                        bit_cnt_d  = bit_cnt_q + bit_cnt_t'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_dout_d  = rx_shift_d;
                            rx_valid_d = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (bit_cnt_q == '0) begin
                            if (hold_full_q) begin
                                tx_shift_d = hold_q;
                                take_hold  = 1'b1;
                            end else begin
                                tx_shift_d = DUMMY_BYTE;
                                underrun_d = 1'b1;
                            end
                        end else begin
                            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A load arriving with an empty register lands even if that same cycle underran.
        if (take_hold) begin
            hold_full_d = 1'b0;
        end
        if (bus.tx_load && !hold_full_q) begin
            hold_d      = bus.tx_din;
            hold_full_d = 1'b1;
        end
    end

    assign bus.busy        = (state_q == StActive);
    assign bus.miso_oe     = (state_q == StActive) && !cs_q;
    assign bus.miso        = bus.miso_oe & tx_shift_q[BYTE_W-1];
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_dout     = rx_dout_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops on cs_n/sclk/mosi (legal range 2..3).
REQ-002 SHALL provide parameter DUMMY_BYTE, default 8'hFF, byte shifted out on tx underrun.
REQ-003 clk  input  1  system clock; SHALL be at least 8x the sclk frequency.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cs_n  input  1  SPI chip select from master, active low, asynchronous to clk.
REQ-006 sclk  input  1  SPI clock from master, mode 3 (idle high), asynchronous to clk.
REQ-007 mosi  input  1  serial data from master, MSB first.
REQ-008 miso  output  1  serial data to master, MSB first.
REQ-009 miso_oe  output  1  miso drive enable, high only while synchronized cs_n is low.
REQ-010 tx_din  input  8  next byte to transmit.
REQ-011 tx_load  input  1  one-cycle strobe; captures tx_din when tx_ready is high.
REQ-012 tx_ready  output  1  transmit holding register empty.
REQ-013 rx_dout  output  8  last complete received byte, held until the next completion.
REQ-014 rx_valid  output  1  one-cycle pulse, rx_dout updated.
REQ-015 tx_underrun  output  1  one-cycle pulse, DUMMY_BYTE substituted.
REQ-016 busy  output  1  high in ACTIVE state.

Function
REQ-017 cs_n, sclk and mosi SHALL pass through SYNC_STAGES flops; sclk rise/fall SHALL be detected from the synchronized value against a one-cycle-delayed copy.
REQ-018 FSM states: IDLE (synced cs_n high), ACTIVE; IDLE->ACTIVE on synced cs_n falling, ACTIVE->IDLE on synced cs_n rising, regardless of bit count.
REQ-019 Bit counter 0..7; SHALL increment on each synced sclk rise in ACTIVE, wrap 7->0, clear on entering IDLE.
REQ-020 On each sclk rise in ACTIVE, synced mosi SHALL shift into rx shift register LSB (MSB-first assembly).
REQ-021 On the sclk rise with bit counter 7, the assembled byte SHALL load rx_dout and rx_valid SHALL pulse the next clk cycle; fixed latency SYNC_STAGES+2 clk from the pin edge.
REQ-022 On each sclk fall in ACTIVE with bit counter 0, tx shift register SHALL load the holding register (or DUMMY_BYTE if empty, with tx_underrun pulse) and miso SHALL present bit 7; other falls SHALL shift to the next lower bit.
REQ-023 Loading the tx shift register SHALL empty the holding register (tx_ready high next cycle).
REQ-024 tx_load while tx_ready low SHALL be ignored; holding register unchanged.
REQ-025 tx_load on the same cycle as a bit-0 fall with empty holding register: underrun SHALL occur, loaded byte stored for the following byte.
REQ-026 Multiple bytes SHALL transfer back-to-back while cs_n stays low, no gap required.
REQ-027 cs_n rise mid-byte: partial rx byte discarded, no rx_valid, tx shift register cleared; holding register content retained.
REQ-028 miso SHALL be 0 while miso_oe is low.

Reset
REQ-029 rst_n low SHALL immediately force: FSM IDLE, bit counter 0, synchronizers to idle values (cs_n=1, sclk=1, mosi=0), miso 0, miso_oe 0, tx_ready 1, rx_dout 8'h00, rx_valid 0, tx_underrun 0, busy 0.
REQ-030 Release of rst_n while cs_n is low SHALL not start a transfer until a fresh cs_n falling edge.

Structure
REQ-031 Shared include spi_defines.vh SHALL hold byte width (8), SPI mode constant (3), and FSM state encodings; existing SPI master and this block use it.
REQ-032 One sub-module spi_sync (N-stage synchronizer with rise/fall outputs) SHALL be instantiated for sclk and cs_n; mosi uses its synchronized output only.

Verification
REQ-033 tx_load 8'hA5, master (16 clk/sclk) sends 8'h3C -> master receives 8'hA5, rx_dout=8'h3C with single rx_valid pulse.
REQ-034 Two back-to-back bytes 8'h01, 8'h80 under one cs_n with tx 8'hC3 then 8'h5A loaded on tx_ready -> two rx_valid pulses, master receives C3,5A, no underrun.
REQ-035 No tx_load before transfer -> master receives 8'hFF, tx_underrun one pulse at first sclk fall.
REQ-036 cs_n deasserted after 5 sclk cycles -> no rx_valid, busy low, next full transfer of 8'h96 received correctly.
REQ-037 rst_n asserted mid-byte -> all outputs at REQ-029 values same cycle; post-reset transfer 8'h7E correct.
REQ-038 tx_load while tx_ready low with 8'h11 after 8'h22 held -> master receives 8'h22.
